// File: rtl/soc_sram_pkg.sv
// Shared definitions for the SRAM arbiter slice: size limits, port-id width helper, return tag.
package soc_sram_pkg;

  localparam int RD_LAT_MAX = 4;
  localparam int MAX_PORTS  = 8;
  localparam int ID_W_MAX   = 3;

  // A single port still needs one id bit so vectors never collapse to zero width
  function automatic int port_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/soc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, plus the pointer for next cycle.
module soc_rr_arbiter
  import soc_sram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PW        = port_id_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        gnt_id,
  output logic                 any,
  output logic [PW-1:0]        next_ptr
);

  int          idx;
  logic [PW-1:0] sel;

  always_comb begin
    gnt      = '0;
    gnt_id   = '0;
    any      = 1'b0;
    idx      = 0;
    sel      = '0;
    next_ptr = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      sel = PW'(idx);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
    if (any) begin
      if (gnt_id == PW'(NUM_PORTS - 1))
        next_ptr = '0;
      else
        next_ptr = gnt_id + PW'(1);
    end
  end

endmodule

// File: rtl/soc_sram_arb.sv
// Round-robin arbiter of NUM_PORTS SRAM masters onto one single-port RAM with tagged read return.
// Optional perf counters (grants / stall cycles per port) when SOC_SRAM_ARB_PERF_EN is defined.
module soc_sram_arb
  import soc_sram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int RAM_AW    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          m_req,
  input  logic [NUM_PORTS*DATA_W/8-1:0] m_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   m_wdata,
  output logic [NUM_PORTS-1:0]          m_gnt,
  output logic [NUM_PORTS-1:0]          m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          ram_en,
  output logic [DATA_W/8-1:0]           ram_we,
  output logic [RAM_AW-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
`ifdef SOC_SRAM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]       perf_gnt_cnt,
  output logic [NUM_PORTS*32-1:0]       perf_stall_cnt
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = port_id_w(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_eff;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        next_ptr;
  logic [PW-1:0]        gnt_id;
  logic                 gnt_any;
  logic                 rd_fire;
  tag_t                 tag_p [RD_LAT];
  tag_t                 tag_out;

  // Nothing is granted while reset is held, so no access can slip into the RAM
  assign req_eff = reset ? '0 : m_req;

  soc_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_arb (
    .req      (req_eff),
    .ptr      (rr_ptr),
    .gnt      (m_gnt),
    .gnt_id   (gnt_id),
    .any      (gnt_any),
    .next_ptr (next_ptr)
  );

  assign ram_en    = gnt_any;
  assign ram_we    = gnt_any ? m_we[int'(gnt_id)*BE_W +: BE_W] : '0;
  assign ram_addr  = m_addr[int'(gnt_id)*ADDR_W + 2 +: RAM_AW];
  assign ram_wdata = m_wdata[int'(gnt_id)*DATA_W +: DATA_W];
  assign rd_fire   = gnt_any && (ram_we == '0);

  // Stage boundary: grant cycle -> tag pipeline, one stage per cycle of RAM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < RD_LAT; i++)
        tag_p[i] <= '0;
    end else begin
      rr_ptr   <= next_ptr;
      tag_p[0] <= '{valid: rd_fire, id: ID_W_MAX'(gnt_id)};
      for (int i = 1; i < RD_LAT; i++)
        tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[RD_LAT-1];
  assign m_rdata = ram_rdata;

  always_comb begin
    m_rvalid = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      m_rvalid[k] = tag_out.valid && !reset && (tag_out.id == ID_W_MAX'(k));
  end

`ifdef SOC_SRAM_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_gnt_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        perf_gnt_cnt[k*32 +: 32]   <= sat_inc(perf_gnt_cnt[k*32 +: 32], m_gnt[k]);
        perf_stall_cnt[k*32 +: 32] <= sat_inc(perf_stall_cnt[k*32 +: 32], m_req[k] & ~m_gnt[k]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_soc_sram_arb.sv
// Directed bench for soc_sram_arb: two ports, RD_LAT=2, 8-bit RAM word address, write-first RAM model.
module tb_soc_sram_arb;

  localparam int NP  = 2;
  localparam int RAW = 8;
  localparam int LAT = 2;

  logic           clk;
  logic           reset;
  logic [NP-1:0]  m_req;
  logic [7:0]     m_we;
  logic [63:0]    m_addr;
  logic [63:0]    m_wdata;
  logic [NP-1:0]  m_gnt;
  logic [NP-1:0]  m_rvalid;
  logic [31:0]    m_rdata;
  logic           ram_en;
  logic [3:0]     ram_we;
  logic [RAW-1:0] ram_addr;
  logic [31:0]    ram_wdata;
  logic [31:0]    ram_rdata;
`ifdef SOC_SRAM_ARB_PERF_EN
  logic [63:0]    perf_gnt_cnt;
  logic [63:0]    perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  soc_sram_arb #(
    .NUM_PORTS (NP),
    .DATA_W    (32),
    .ADDR_W    (32),
    .RAM_AW    (RAW),
    .RD_LAT    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_gnt     (m_gnt),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef SOC_SRAM_ARB_PERF_EN
    ,
    .perf_gnt_cnt   (perf_gnt_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first RAM with LAT-cycle read pipeline
  logic [31:0] mem   [1<<RAW];
  logic [31:0] rpipe [LAT];

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
      rpipe[0] <= mem[ram_addr];
    end else begin
      rpipe[0] <= 32'h0;
    end
    for (int i = 1; i < LAT; i++)
      rpipe[i] <= rpipe[i-1];
  end

  assign ram_rdata = rpipe[LAT-1];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input int p, input logic rq, input logic [3:0] we,
                     input logic [31:0] a, input logic [31:0] d);
    m_req[p]          = rq;
    m_we[p*4 +: 4]    = we;
    m_addr[p*32 +: 32]  = a;
    m_wdata[p*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Contention table: ports read 0x200 (A0A00000) and 0x304 (B1B11111), pointer starts at 0
    tbl[0]  = '{2'b11, 2'b01, 2'b00, 32'h0};
    tbl[1]  = '{2'b11, 2'b10, 2'b00, 32'h0};
    tbl[2]  = '{2'b11, 2'b01, 2'b01, 32'hA0A0_0000};
    tbl[3]  = '{2'b11, 2'b10, 2'b10, 32'hB1B1_1111};
    tbl[4]  = '{2'b10, 2'b10, 2'b01, 32'hA0A0_0000};
    tbl[5]  = '{2'b10, 2'b10, 2'b10, 32'hB1B1_1111};
    tbl[6]  = '{2'b01, 2'b01, 2'b10, 32'hB1B1_1111};
    tbl[7]  = '{2'b00, 2'b00, 2'b10, 32'hB1B1_1111};
    tbl[8]  = '{2'b11, 2'b10, 2'b01, 32'hA0A0_0000};
    tbl[9]  = '{2'b01, 2'b01, 2'b00, 32'h0};
    tbl[10] = '{2'b01, 2'b01, 2'b10, 32'hB1B1_1111};
    tbl[11] = '{2'b00, 2'b00, 2'b01, 32'hA0A0_0000};
    tbl[12] = '{2'b00, 2'b00, 2'b01, 32'hA0A0_0000};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 32'h0};

    reset = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {m_gnt, ram_en, ram_we, m_rvalid}, 64'h0);
      tick();
    end

    // Write then read back with latency LAT
    drv(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_gnt", m_gnt, 64'h1);
    check("wr_we", ram_we, 64'hF);
    check("wr_addr", ram_addr, 64'h40);
    check("wr_data", ram_wdata, 64'hDEADBEEF);
    tick();
    drv(0, 1'b1, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    check("rd_gnt", {m_gnt, ram_en, ram_we}, {57'h0, 2'b01, 1'b1, 4'h0});
    check("wr_no_rv", m_rvalid, 64'h0);
    tick();
    drv(0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rv_early", m_rvalid, 64'h0);
    tick();
    @(negedge clk);
    check("rv_lat", m_rvalid, 64'h1);
    check("rd_data", m_rdata, 64'hDEADBEEF);
    tick();
    @(negedge clk);
    check("rv_once", m_rvalid, 64'h0);

    // Byte-lane write on port 1
    tick();
    drv(1, 1'b1, 4'hF, 32'h108, 32'h11223344);
    @(negedge clk);
    check("bw_gnt0", m_gnt, 64'h2);
    tick();
    drv(1, 1'b1, 4'b0010, 32'h108, 32'h0000AB00);
    @(negedge clk);
    check("bw_gnt1", m_gnt, 64'h2);
    tick();
    drv(1, 1'b1, 4'h0, 32'h108, 32'h0);
    @(negedge clk);
    check("bw_gnt2", m_gnt, 64'h2);
    tick();
    drv(1, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    check("bw_rv", m_rvalid, 64'h2);
    check("bw_data", m_rdata, 64'h1122AB44);

    // High and low address bits are dropped
    tick();
    drv(0, 1'b1, 4'h0, 32'hFFFFF50B, 32'h0);
    @(negedge clk);
    check("wrap_addr", ram_addr, 64'h42);
    tick();
    drv(0, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Preload table data through the arbiter
    drv(0, 1'b1, 4'hF, 32'h200, 32'hA0A00000);
    tick();
    drv(0, 1'b0, 4'h0, 32'h200, 32'h0);
    drv(1, 1'b1, 4'hF, 32'h304, 32'hB1B11111);
    tick();
    drv(1, 1'b0, 4'h0, 32'h304, 32'h0);

    for (int i = 0; i < 14; i++) begin
      m_req = tbl[i].req;
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", i), m_gnt, 64'(tbl[i].gnt));
      check($sformatf("tbl%0d_rv", i), m_rvalid, 64'(tbl[i].rv));
      if (tbl[i].rv != 2'b00)
        check($sformatf("tbl%0d_data", i), m_rdata, 64'(tbl[i].rdata));
      tick();
    end
    m_req = '0;

    // Reset with reads in flight; pointer is 1 before reset
    m_req = 2'b01;
    @(negedge clk);
    check("rst_pre_gnt0", m_gnt, 64'h1);
    tick();
    @(negedge clk);
    check("rst_pre_gnt1", m_gnt, 64'h1);
    tick();
    reset = 1'b1;
    m_req = 2'b11;
    @(negedge clk);
    check("rst_gnt", {m_gnt, ram_en}, 64'h0);
    check("rst_rv", m_rvalid, 64'h0);
    tick();
    reset = 1'b0;
    m_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_flush", m_rvalid, 64'h0);
      tick();
    end
    m_req = 2'b11;
    @(negedge clk);
    check("rst_ptr", m_gnt, 64'h1);
    tick();
    m_req = 2'b00;
    @(negedge clk);
    check("post_rv0", m_rvalid, 64'h0);
    tick();
    @(negedge clk);
    check("post_rv", m_rvalid, 64'h1);
    check("post_data", m_rdata, 64'hA0A00000);
    tick();

`ifdef SOC_SRAM_ARB_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_req = 2'b11;
    repeat (5) tick();
    m_req = 2'b00;
    @(negedge clk);
    check("perf_gnt0", perf_gnt_cnt[31:0], 64'd3);
    check("perf_gnt1", perf_gnt_cnt[63:32], 64'd2);
    check("perf_stall0", perf_stall_cnt[31:0], 64'd2);
    check("perf_stall1", perf_stall_cnt[63:32], 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
